// File: rtl/uart_pkg.sv
// Shared definitions for the debug-link UART command receiver.
//   - byte_state_e  : byte deserialiser FSM encoding
//   - frame_state_e : command frame parser FSM encoding
//   - SYNC_BYTE_DEFAULT and the command codes understood by top-level control
//   - frame_csum()  : checksum of a SYNC/CMD/ARG triple
package uart_pkg;

  typedef enum logic [2:0] {
    ByteIdle,
    ByteStart,
    ByteData,
    ByteStop,
    ByteBreak
  } byte_state_e;

  typedef enum logic [1:0] {
    FrameWaitSync,
    FrameGetCmd,
    FrameGetArg,
    FrameGetCsum
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_HALT  = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_STEP  = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'h04;

  function automatic logic [7:0] frame_csum(input logic [7:0] sync_b, input logic [7:0] cmd_b,
                                            input logic [7:0] arg_b);
    return sync_b ^ cmd_b ^ arg_b;
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Output bundle of the UART command receiver.
//   byte_valid/byte_data : received-byte strobe and value
//   cmd_valid/cmd/arg    : validated command strobe and its fields
//   frame_err, csum_err, timeout_err : one-cycle error strobes
//   err_count            : saturating error count
// master: driven by uart_cmd_rx; slave: consumed by halt/step/reset control.
interface uart_cmd_rx_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic       frame_err;
  logic       csum_err;
  logic       timeout_err;
  logic [7:0] err_count;

  modport master (
    output byte_valid, byte_data, cmd_valid, cmd, arg,
    output frame_err, csum_err, timeout_err, err_count
  );

  modport slave (
    input byte_valid, byte_data, cmd_valid, cmd, arg,
    input frame_err, csum_err, timeout_err, err_count
  );
endinterface

// File: rtl/uart_cmd_rx_byte.sv
// 8N1 byte deserialiser: 2-FF input synchroniser, bit timer and byte FSM.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   byte_valid : one-cycle strobe, byte_data holds a correctly framed byte
//   byte_data  : last correctly framed byte
//   frame_err  : one-cycle strobe, stop bit sampled low
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  // Timer counts down to zero; the sample happens on the cycle it reads zero.
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q;
  logic            rx_s_q;
  logic            rx_prev_q;
  byte_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q;
  logic [7:0]      byte_data_q;
  logic            frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= ByteIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        ByteIdle: begin
          if (rx_prev_q && !rx_s_q) begin
            cnt_q   <= HalfLoad;
            state_q <= ByteStart;
          end
        end

        ByteStart: begin
          if (cnt_q == '0) begin
            if (rx_s_q) begin
              // Line back high at mid start bit: glitch, not a character.
              state_q <= ByteIdle;
            end else begin
              cnt_q   <= BitLoad;
              bit_q   <= '0;
              state_q <= ByteData;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ByteData: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            cnt_q   <= BitLoad;
            if (bit_q == 3'd7) begin
              state_q <= ByteStop;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ByteStop: begin
          if (cnt_q == '0) begin
            if (rx_s_q) begin
              byte_valid_q <= 1'b1;
              byte_data_q  <= shift_q;
              state_q      <= ByteIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ByteBreak;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ByteBreak: begin
          // A held-low line reports one framing error, then waits for idle.
          if (rx_s_q) begin
            state_q <= ByteIdle;
          end
        end

        default: state_q <= ByteIdle;
      endcase
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver for the debug link. Deserialises 8N1 bytes from rx and parses
// 4-byte frames SYNC, CMD, ARG, CSUM (CSUM = SYNC ^ CMD ^ ARG).
// Ports:
//   clk, rst : 12 MHz board clock, synchronous active-high reset
//   rx       : asynchronous serial input, idle high
//   bus      : uart_cmd_rx_if.master output bundle (byte, command and error strobes)
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TIMEOUT_BITS = 32,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_cmd_rx_if.master bus
);

  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TmoW          = $clog2(TimeoutCycles);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(TimeoutCycles - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  frame_state_e    state_q;
  logic [7:0]      cmd_lat_q;
  logic [7:0]      arg_lat_q;
  logic [7:0]      cmd_q;
  logic [7:0]      arg_q;
  logic            cmd_valid_q;
  logic            csum_err_q;
  logic            timeout_err_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic [7:0]      err_count_q;
  logic            err_any;

  // Strobes never overlap a cycle boundary, so OR-ing them counts coincident ones once.
  assign err_any = frame_err | csum_err_q | timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FrameWaitSync;
      cmd_lat_q     <= '0;
      arg_lat_q     <= '0;
      cmd_q         <= '0;
      arg_q         <= '0;
      cmd_valid_q   <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
      err_count_q   <= '0;
    end else begin
      cmd_valid_q   <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;

      // byte_valid is checked first so it beats a coincident timeout.
      if (byte_valid) begin
        tmo_cnt_q <= '0;
        case (state_q)
          FrameWaitSync: begin
            if (byte_data == SYNC_BYTE) begin
              state_q <= FrameGetCmd;
            end
          end
          FrameGetCmd: begin
            cmd_lat_q <= byte_data;
            state_q   <= FrameGetArg;
          end
          FrameGetArg: begin
            arg_lat_q <= byte_data;
            state_q   <= FrameGetCsum;
          end
          FrameGetCsum: begin
            if (byte_data == frame_csum(SYNC_BYTE, cmd_lat_q, arg_lat_q)) begin
              cmd_valid_q <= 1'b1;
              cmd_q       <= cmd_lat_q;
              arg_q       <= arg_lat_q;
            end else begin
              csum_err_q <= 1'b1;
            end
            state_q <= FrameWaitSync;
          end
          default: state_q <= FrameWaitSync;
        endcase
      end else if (state_q != FrameWaitSync) begin
        if (frame_err) begin
          state_q   <= FrameWaitSync;
          tmo_cnt_q <= '0;
        end else if (tmo_cnt_q == TmoLast) begin
          timeout_err_q <= 1'b1;
          state_q       <= FrameWaitSync;
          tmo_cnt_q     <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end

      if (err_any && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign bus.byte_valid  = byte_valid;
  assign bus.byte_data   = byte_data;
  assign bus.frame_err   = frame_err;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd         = cmd_q;
  assign bus.arg         = arg_q;
  assign bus.csum_err    = csum_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: serial stimulus driven on the falling clock edge,
// outputs observed on the falling edge, expectations from a frame-level parser model.
module tb_uart_cmd_rx;
  import uart_pkg::*;

  localparam int unsigned CPB  = 8;
  // Four bit times would expire inside a single 10-bit character, so use 32.
  localparam int unsigned TOB  = 32;
  localparam int unsigned TMO  = CPB * TOB;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_cmd_rx_if bus ();

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of DUT strobes
  logic [7:0]  got_bytes[$];
  logic [15:0] got_cmds[$];
  int n_csum = 0, n_frame = 0, n_tmo = 0;
  int last_bv = 0, last_cv = 0, last_tmo = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.byte_valid) begin
        got_bytes.push_back(bus.byte_data);
        last_bv <= cyc;
      end
      if (bus.cmd_valid) begin
        got_cmds.push_back({bus.cmd, bus.arg});
        last_cv <= cyc;
      end
      if (bus.csum_err) n_csum <= n_csum + 1;
      if (bus.frame_err) n_frame <= n_frame + 1;
      if (bus.timeout_err) begin
        n_tmo    <= n_tmo + 1;
        last_tmo <= cyc;
      end
    end
  end

  // Reference model: frame position 0..3 plus latched fields
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_cmds[$];
  int          m_pos = 0;
  logic [7:0]  m_cmd = 0, m_arg = 0, exp_cmd = 0, exp_arg = 0;
  int          exp_csum = 0, exp_frame = 0, exp_tmo = 0, exp_err = 0;
  int          start_cyc = 0;
  int          errors = 0, checks = 0;

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    case (m_pos)
      0: if (b == SYNC) m_pos = 1;
      1: begin m_cmd = b; m_pos = 2; end
      2: begin m_arg = b; m_pos = 3; end
      default: begin
        if (b == (SYNC ^ m_cmd ^ m_arg)) begin
          exp_cmds.push_back({m_cmd, m_arg});
          exp_cmd = m_cmd;
          exp_arg = m_arg;
        end else begin
          exp_csum++;
          bump_err();
        end
        m_pos = 0;
      end
    endcase
  endtask

  task automatic model_frame_err();
    exp_frame++;
    bump_err();
    m_pos = 0;
  endtask

  task automatic model_idle_timeout();
    if (m_pos != 0) begin
      exp_tmo++;
      bump_err();
      m_pos = 0;
    end
  endtask

  // Stimulus
  task automatic bit_wait(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    bit_wait(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_wait(1);
    end
    rx = stop;
    bit_wait(1);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_byte(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.byte_valid, bus.cmd_valid, bus.frame_err, bus.csum_err, bus.timeout_err,
         bus.byte_data, bus.cmd, bus.arg, bus.err_count} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {bus.byte_valid, bus.cmd_valid,
               bus.frame_err, bus.csum_err, bus.timeout_err, bus.byte_data, bus.cmd, bus.arg,
               bus.err_count});
    end
    rst = 1'b0;
    bit_wait(2);
    checks++;
    if (got_bytes.size() != 0 || n_frame != 0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL idle_after_reset: bytes=%0d frame_errs=%0d err_count=%0d required 0/0/0",
               got_bytes.size(), n_frame, bus.err_count);
    end
  endtask

  task automatic test_single_frame();
    send_good(SYNC);
    send_good(8'h01);
    send_good(8'h7C);
    send_good(8'hD8);
    bit_wait(2);
    checks++;
    if (got_bytes.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL single_byte_count: got %0d required %0d", got_bytes.size(),
               exp_bytes.size());
    end else begin
      foreach (exp_bytes[i]) begin
        checks++;
        if (got_bytes[i] !== exp_bytes[i]) begin
          errors++;
          $display("FAIL single_byte[%0d]: got %h required %h", i, got_bytes[i], exp_bytes[i]);
        end
      end
    end
    checks++;
    if (got_cmds.size() != 1 || bus.cmd !== 8'h01 || bus.arg !== 8'h7C) begin
      errors++;
      $display("FAIL single_cmd: got n=%0d cmd=%h arg=%h required n=1 cmd=01 arg=7c",
               got_cmds.size(), bus.cmd, bus.arg);
    end
    checks++;
    if (bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL single_err_count: got %0d required 0", bus.err_count);
    end
    checks++;
    if (last_bv - start_cyc < 78 || last_bv - start_cyc > 80) begin
      errors++;
      $display("FAIL byte_latency: got %0d required 79+-1", last_bv - start_cyc);
    end
    checks++;
    if (last_cv - last_bv != 1) begin
      errors++;
      $display("FAIL cmd_latency: got %0d required 1", last_cv - last_bv);
    end
  endtask

  task automatic test_csum_err();
    send_good(SYNC);
    send_good(8'h02);
    send_good(8'h10);
    send_good(8'h00);
    bit_wait(2);
    checks++;
    if (n_csum != exp_csum || got_cmds.size() != exp_cmds.size()) begin
      errors++;
      $display("FAIL csum_bad: got csum_errs=%0d cmds=%0d required %0d/%0d", n_csum,
               got_cmds.size(), exp_csum, exp_cmds.size());
    end
    checks++;
    if (bus.err_count !== 8'(exp_err) || bus.cmd !== exp_cmd || bus.arg !== exp_arg) begin
      errors++;
      $display("FAIL csum_hold: got err=%0d cmd=%h arg=%h required %0d %h %h", bus.err_count,
               bus.cmd, bus.arg, exp_err, exp_cmd, exp_arg);
    end
    send_good(SYNC);
    send_good(8'h02);
    send_good(8'h10);
    send_good(8'hB7);
    bit_wait(2);
    checks++;
    if (bus.cmd !== 8'h02 || bus.arg !== 8'h10 || got_cmds.size() != exp_cmds.size()) begin
      errors++;
      $display("FAIL csum_good: got cmd=%h arg=%h n=%0d required 02 10 n=%0d", bus.cmd,
               bus.arg, got_cmds.size(), exp_cmds.size());
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    bit_wait(2);
    checks++;
    if (got_bytes.size() != exp_bytes.size() || n_frame != exp_frame) begin
      errors++;
      $display("FAIL glitch_quiet: got bytes=%0d frame_errs=%0d required %0d/%0d",
               got_bytes.size(), n_frame, exp_bytes.size(), exp_frame);
    end
    send_good(SYNC);
    send_good(CMD_STEP);
    send_good(8'h00);
    send_good(8'hA6);
    bit_wait(2);
    checks++;
    if (bus.cmd !== 8'h03 || got_cmds.size() != exp_cmds.size()) begin
      errors++;
      $display("FAIL glitch_frame: got cmd=%h n=%0d required 03 n=%0d", bus.cmd,
               got_cmds.size(), exp_cmds.size());
    end
  endtask

  task automatic test_break();
    send_good(SYNC);
    send_good(8'h05);
    send_byte(8'h3C, 1'b0);
    model_frame_err();
    bit_wait(50);
    rx = 1'b1;
    bit_wait(2);
    checks++;
    if (n_frame != exp_frame || got_bytes.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL break_once: got frame_errs=%0d bytes=%0d required %0d/%0d", n_frame,
               got_bytes.size(), exp_frame, exp_bytes.size());
    end
    send_good(SYNC);
    send_good(CMD_HALT);
    send_good(8'h22);
    send_good(SYNC ^ CMD_HALT ^ 8'h22);
    bit_wait(2);
    checks++;
    if (bus.cmd !== 8'h01 || bus.arg !== 8'h22 || got_cmds.size() != exp_cmds.size() ||
        bus.err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL break_recover: got cmd=%h arg=%h n=%0d err=%0d required 01 22 n=%0d %0d",
               bus.cmd, bus.arg, got_cmds.size(), bus.err_count, exp_cmds.size(), exp_err);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] xx;
    send_good(SYNC);
    send_good(CMD_RESET);
    bit_wait(40);
    model_idle_timeout();
    checks++;
    if (n_tmo != exp_tmo || bus.err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL timeout_once: got tmo=%0d err=%0d required %0d/%0d", n_tmo,
               bus.err_count, exp_tmo, exp_err);
    end
    checks++;
    if (last_tmo - last_bv < TMO || last_tmo - last_bv > TMO + 2) begin
      errors++;
      $display("FAIL timeout_delay: got %0d required %0d+-1", last_tmo - last_bv, TMO + 1);
    end
    xx = 8'($urandom);
    if (xx == SYNC) xx = xx ^ 8'h01;
    send_good(8'h7E);
    send_good(8'h04);
    send_good(8'h00);
    send_good(xx);
    bit_wait(2);
    checks++;
    if (got_cmds.size() != exp_cmds.size() || n_tmo != exp_tmo) begin
      errors++;
      $display("FAIL timeout_resync: got cmds=%0d tmo=%0d required %0d/%0d", got_cmds.size(),
               n_tmo, exp_cmds.size(), exp_tmo);
    end
  endtask

  task automatic test_random();
    logic [7:0] c, a, s;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_good(8'($urandom));
      end else begin
        c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 4)) : 8'($urandom);
        a = 8'($urandom);
        s = SYNC ^ c ^ a;
        if ($urandom_range(0, 3) == 0) s = s ^ (8'd1 << $urandom_range(0, 7));
        send_good(SYNC);
        bit_wait($urandom_range(0, 4));
        send_good(c);
        bit_wait($urandom_range(0, 4));
        send_good(a);
        bit_wait($urandom_range(0, 4));
        send_good(s);
      end
      bit_wait($urandom_range(0, 4));
    end
    bit_wait(40);
    model_idle_timeout();
    checks++;
    if (got_bytes.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL rand_byte_count: got %0d required %0d", got_bytes.size(),
               exp_bytes.size());
    end
    checks++;
    if (got_cmds.size() != exp_cmds.size()) begin
      errors++;
      $display("FAIL rand_cmd_count: got %0d required %0d", got_cmds.size(), exp_cmds.size());
    end else begin
      foreach (exp_cmds[i]) begin
        checks++;
        if (got_cmds[i] !== exp_cmds[i]) begin
          errors++;
          $display("FAIL rand_cmd[%0d]: got %h required %h", i, got_cmds[i], exp_cmds[i]);
        end
      end
    end
    checks++;
    if (n_csum != exp_csum || n_tmo != exp_tmo || bus.err_count !== 8'(exp_err) ||
        bus.cmd !== exp_cmd || bus.arg !== exp_arg) begin
      errors++;
      $display("FAIL rand_state: got csum=%0d tmo=%0d err=%0d cmd=%h arg=%h required %0d %0d %0d %h %h",
               n_csum, n_tmo, bus.err_count, bus.cmd, bus.arg, exp_csum, exp_tmo, exp_err,
               exp_cmd, exp_arg);
    end
  endtask

  task automatic test_saturation_reset();
    int bytes_before;
    repeat (300) begin
      send_byte(8'($urandom), 1'b0);
      model_frame_err();
      rx = 1'b1;
      bit_wait(1);
    end
    bit_wait(1);
    checks++;
    if (n_frame != exp_frame || bus.err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturation: got frame_errs=%0d err=%0d required %0d/255", n_frame,
               bus.err_count, exp_frame);
    end
    // Reset in the middle of a character
    bytes_before = got_bytes.size();
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.byte_valid, bus.cmd_valid, bus.frame_err, bus.csum_err, bus.timeout_err,
         bus.byte_data, bus.cmd, bus.arg, bus.err_count} !== 37'd0) begin
      errors++;
      $display("FAIL midbyte_reset: got %h required 0", {bus.byte_valid, bus.cmd_valid,
               bus.frame_err, bus.csum_err, bus.timeout_err, bus.byte_data, bus.cmd, bus.arg,
               bus.err_count});
    end
    rx  = 1'b1;
    rst = 1'b0;
    exp_err = 0;
    exp_cmd = 0;
    exp_arg = 0;
    m_pos   = 0;
    bit_wait(3);
    checks++;
    if (got_bytes.size() != bytes_before || n_frame != exp_frame) begin
      errors++;
      $display("FAIL reset_discard: got bytes=%0d frame_errs=%0d required %0d/%0d",
               got_bytes.size(), n_frame, bytes_before, exp_frame);
    end
    send_good(SYNC);
    send_good(CMD_RESET);
    send_good(8'h5A);
    send_good(SYNC ^ CMD_RESET ^ 8'h5A);
    bit_wait(2);
    checks++;
    if (bus.cmd !== 8'h04 || bus.arg !== 8'h5A || bus.err_count !== 8'd0 ||
        got_cmds.size() != exp_cmds.size()) begin
      errors++;
      $display("FAIL post_reset_frame: got cmd=%h arg=%h err=%0d n=%0d required 04 5a 0 n=%0d",
               bus.cmd, bus.arg, bus.err_count, got_cmds.size(), exp_cmds.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_csum_err();
    test_glitch();
    test_break();
    test_timeout();
    test_random();
    test_saturation_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
